// File: rtl/mhsa_pkg.sv
// Shared definitions for the MHSA host DMA: default widths and the job FSM encoding.
package mhsa_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_KICK  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_STORE = 3'd4
  } state_e;
endpackage

// File: rtl/mhsa_rd_skid.sv
// Two-entry valid/ready FIFO holding SRAM read returns until the result stream takes them.
module mhsa_rd_skid #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);
  logic [DATA_W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              push_s, pop_s;

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_comb begin
    in_ready  = (cnt_q != 2'd2);
    out_valid = (cnt_q != 2'd0);
    out_data  = e0_q;
    count     = cnt_q;
    push_s    = in_valid && in_ready;
    pop_s     = out_valid && out_ready;
    e0_d      = e0_q;
    e1_d      = e1_q;
    cnt_d     = cnt_q;
    case ({push_s, pop_s})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) e0_d = in_data;
        else               e1_d = in_data;
      end
      2'b01: begin
        cnt_d = cnt_q - 2'd1;
        e0_d  = e1_q;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = in_data;
        end else begin
          e0_d = e1_q;
          e1_d = in_data;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mhsa_host_dma.sv
// Host-side DMA for the MHSA accelerator: streams a job's input into SRAM, kicks the
// accelerator, waits for done, then streams the result region back out.
module mhsa_host_dma
  import mhsa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_input_base,
  input  logic [ADDR_W-1:0] cmd_output_base,
  input  logic [LEN_W-1:0]  cmd_load_len,
  input  logic [LEN_W-1:0]  cmd_store_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              soc_write_en,
  output logic [ADDR_W-1:0] soc_addr,
  output logic [DATA_W-1:0] soc_data_in,
  input  logic [DATA_W-1:0] soc_data_out,
  output logic              start,
  output logic [ADDR_W-1:0] input_base,
  output logic [ADDR_W-1:0] output_base,
  input  logic              done,
  output logic              busy
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] in_base_q, in_base_d, out_base_q, out_base_d;
  logic [LEN_W-1:0]  load_len_q, load_len_d, store_len_q, store_len_d;
  logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, out_cnt_q, out_cnt_d;
  logic              inflight_q, inflight_d;
  logic              skid_in_ready_s, skid_out_valid_s, pop_s, space_s;
  logic [1:0]        skid_cnt_s;

  mhsa_rd_skid #(.DATA_W(DATA_W)) u_rd_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inflight_q),
    .in_ready  (skid_in_ready_s),
    .in_data   (soc_data_out),
    .out_valid (skid_out_valid_s),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (skid_cnt_s)
  );

  assign busy        = (state_q != ST_IDLE);
  assign cmd_ready   = !busy;
  assign input_base  = in_base_q;
  assign output_base = out_base_q;
  assign out_valid   = skid_out_valid_s;
  assign out_last    = skid_out_valid_s && (out_cnt_q == store_len_q - LEN_W'(1));
  assign pop_s       = skid_out_valid_s && out_ready;
  // Reads in flight count against the buffer so a returning word always has a slot.
  assign space_s     = (({1'b0, skid_cnt_s} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s}))
                       && (skid_in_ready_s || pop_s);

  always_comb begin
    state_d      = state_q;
    in_base_d    = in_base_q;
    out_base_d   = out_base_q;
    load_len_d   = load_len_q;
    store_len_d  = store_len_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    out_cnt_d    = out_cnt_q;
    inflight_d   = 1'b0;
    in_ready     = 1'b0;
    soc_write_en = 1'b0;
    soc_data_in  = '0;
    soc_addr     = in_base_q + ADDR_W'(wr_cnt_q);
    start        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          in_base_d   = cmd_input_base;
          out_base_d  = cmd_output_base;
          load_len_d  = cmd_load_len;
          store_len_d = cmd_store_len;
          wr_cnt_d    = '0;
          rd_cnt_d    = '0;
          out_cnt_d   = '0;
          state_d     = (cmd_load_len == '0) ? ST_KICK : ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          soc_write_en = 1'b1;
          soc_data_in  = in_data;
          wr_cnt_d     = wr_cnt_q + LEN_W'(1);
          state_d      = (wr_cnt_q == load_len_q - LEN_W'(1)) ? ST_KICK : ST_LOAD;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_KICK: begin
        start   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        start = 1'b1;
        if (done) state_d = (store_len_q == '0) ? ST_IDLE : ST_STORE;
        else      state_d = ST_WAIT;
      end
      ST_STORE: begin
        soc_addr = out_base_q + ADDR_W'(rd_cnt_q);
        if ((rd_cnt_q != store_len_q) && space_s) begin
          inflight_d = 1'b1;
          rd_cnt_d   = rd_cnt_q + LEN_W'(1);
        end else begin
          inflight_d = 1'b0;
        end
        if (pop_s) begin
          out_cnt_d = out_cnt_q + LEN_W'(1);
          state_d   = out_last ? ST_IDLE : ST_STORE;
        end else begin
          state_d = ST_STORE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_base_q   <= '0;
      out_base_q  <= '0;
      load_len_q  <= '0;
      store_len_q <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_base_q   <= in_base_d;
      out_base_q  <= out_base_d;
      load_len_q  <= load_len_d;
      store_len_q <= store_len_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= inflight_d;
    end
  end
endmodule

// File: tb/tb_mhsa_host_dma.sv
// Randomized bench for mhsa_host_dma: SRAM and accelerator are modelled here, and every
// write and output word is checked against per-job expectations built from the job rules.
module tb_mhsa_host_dma;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_input_base, cmd_output_base;
  logic [LW-1:0] cmd_load_len, cmd_store_len;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic          soc_write_en;
  logic [AW-1:0] soc_addr;
  logic [DW-1:0] soc_data_in, soc_data_out;
  logic          start, done, busy;
  logic [AW-1:0] input_base, output_base;

  mhsa_host_dma #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_input_base(cmd_input_base), .cmd_output_base(cmd_output_base),
    .cmd_load_len(cmd_load_len), .cmd_store_len(cmd_store_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .soc_write_en(soc_write_en), .soc_addr(soc_addr), .soc_data_in(soc_data_in),
    .soc_data_out(soc_data_out),
    .start(start), .input_base(input_base), .output_base(output_base),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] exp_wr_addr[$];
  logic [DW-1:0] exp_wr_data[$];
  logic [DW-1:0] exp_out[$];
  int            got = 0;
  int            cur_sl = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SRAM read port: data for the address presented this cycle appears next cycle.
  always @(posedge clk) begin
    soc_data_out <= mem.exists(soc_addr) ? mem[soc_addr] : 64'd0;
  end

  // Mid-cycle monitor: commits SRAM writes and checks every write and every output beat.
  initial forever begin
    @(negedge clk);
    #2;
    if (soc_write_en === 1'b1) begin
      check_value("wr_allowed", 64'(exp_wr_addr.size() != 0), 64'd1);
      if (exp_wr_addr.size() != 0) begin
        check_value("wr_addr", 64'(soc_addr), 64'(exp_wr_addr.pop_front()));
        check_value("wr_data", soc_data_in, exp_wr_data.pop_front());
      end
      mem[soc_addr] = soc_data_in;
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      check_value("out_allowed", 64'(exp_out.size() != 0), 64'd1);
      if (exp_out.size() != 0) begin
        check_value("out_data", out_data, exp_out.pop_front());
        check_value("out_last", 64'(out_last), 64'(got == cur_sl - 1));
      end
      got++;
    end
  end

  task automatic run_job(input logic [AW-1:0] ib, input logic [AW-1:0] ob, input int ll,
                         input int sl, input int dly, input int mode, input bit dense,
                         input bit abort);
    logic [DW-1:0] d;
    logic [DW-1:0] ld[$];
    int idx, cyc, t, lcyc;
    got = 0;
    cur_sl = sl;
    exp_out.delete();
    for (int j = 0; j < sl; j++) begin
      d = {$urandom, $urandom};
      mem[ob + 32'(j)] = d;
      exp_out.push_back(d);
    end
    for (int k = 0; k < ll; k++) begin
      d = dense ? 64'((k + 1) * 17) : {$urandom, $urandom};
      ld.push_back(d);
      exp_wr_addr.push_back(ib + 32'(k));
      exp_wr_data.push_back(d);
    end

    @(negedge clk);
    cmd_valid = 1'b1; cmd_input_base = ib; cmd_output_base = ob;
    cmd_load_len = LW'(ll); cmd_store_len = LW'(sl);
    t = 0;
    #1;
    while (!cmd_ready && t < 50) begin @(negedge clk); #1; t++; end
    check_value("cmd_accept", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;

    idx = 0; lcyc = 0;
    while (idx < ll && lcyc < 20 * ll + 50) begin
      in_valid = dense || ($urandom_range(3) != 0);
      in_data  = ld[idx];
      done     = 1'($urandom_range(1));
      #1;
      if (in_valid && in_ready) idx++;
      lcyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    done = 1'b0;
    check_value("load_beats", 64'(idx), 64'(ll));
    if (dense) check_value("load_cycles", 64'(lcyc), 64'(ll));
    check_value("start_kick", 64'(start), 64'd1);
    check_value("in_ready_kick", 64'(in_ready), 64'd0);
    check_value("in_base_hold", 64'(input_base), 64'(ib));
    check_value("out_base_hold", 64'(output_base), 64'(ob));

    for (int c = 0; c < dly; c++) begin
      @(negedge clk);
      check_value("start_wait", 64'(start), 64'd1);
    end

    if (abort) begin
      #1 rst_n = 1'b0;
      #1;
      check_value("rst_start", 64'(start), 64'd0);
      check_value("rst_busy", 64'(busy), 64'd0);
      check_value("rst_wen", 64'(soc_write_en), 64'd0);
      check_value("rst_out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_value("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      exp_out.delete();
      cur_sl = 0;
      got = 0;
      repeat (3) @(negedge clk);
      check_value("rst_no_out", 64'(got), 64'd0);
      return;
    end

    done = 1'b1;
    if (mode == 1) out_ready = 1'b1;
    cyc = 0;
    while (cyc < 4 * sl + 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check_value("start_drop", 64'(start), 64'd0);
        done = 1'b0;
      end
      case (mode)
        1:       out_ready = 1'b1;
        2:       out_ready = cyc[0];
        default: begin
          out_ready = 1'($urandom_range(1));
          done = 1'($urandom_range(1));
        end
      endcase
      if (mode == 1 && sl > 0 && cyc == 2) check_value("first_valid_early", 64'(out_valid), 64'd0);
      if (mode == 1 && sl > 0 && cyc == 3) check_value("first_valid", 64'(out_valid), 64'd1);
      #3;
      if (got >= sl) break;
    end
    check_value("store_words", 64'(got), 64'(sl));
    if (mode == 1 && sl > 0) check_value("store_cycles", 64'(cyc), 64'(sl + 2));
    if (sl != 0) @(negedge clk);
    out_ready = 1'b0;
    done = 1'b0;
    check_value("idle_busy", 64'(busy), 64'd0);
    check_value("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    check_value("wr_leftover", 64'(exp_wr_addr.size()), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] rb;
    cmd_valid = 1'b0; cmd_input_base = '0; cmd_output_base = '0;
    cmd_load_len = '0; cmd_store_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; done = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_value("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_value("rst_busy", 64'(busy), 64'd0);
    check_value("rst_start", 64'(start), 64'd0);
    check_value("rst_wen", 64'(soc_write_en), 64'd0);
    check_value("rst_out_valid", 64'(out_valid), 64'd0);
    check_value("rst_out_last", 64'(out_last), 64'd0);
    check_value("rst_in_ready", 64'(in_ready), 64'd0);
    check_value("rst_in_base", 64'(input_base), 64'd0);
    check_value("rst_out_base", 64'(output_base), 64'd0);
    check_value("rst_soc_addr", 64'(soc_addr), 64'd0);
    check_value("rst_soc_data_in", soc_data_in, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_job(32'd0, 32'd2048, 4, 512, 10, 1, 1'b1, 1'b0);
    rb = $urandom;
    run_job(rb, rb ^ 32'h8000_0000, 7, 20, 3, 2, 1'b0, 1'b0);
    rb = $urandom;
    run_job(rb, rb ^ 32'h8000_0000, 0, 0, 2, 1, 1'b0, 1'b0);
    run_job(32'hFFFF_FFFE, 32'h7000_0000, 4, 6, 4, 1, 1'b1, 1'b0);
    rb = $urandom;
    run_job(rb, rb ^ 32'h8000_0000, 3, 5, 4, 1, 1'b0, 1'b1);
    rb = $urandom;
    run_job(rb, rb ^ 32'h8000_0000, 5, 9, 2, 1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rb = $urandom;
      run_job(rb, rb ^ 32'h8000_0000, int'($urandom_range(12)), int'($urandom_range(24)),
              int'($urandom_range(6, 1)), int'($urandom_range(3, 1)), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mhsa_host_dma.md
MHSA_HOST_DMA -- requirements
Module: mhsa_host_dma

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning SRAM/stream word width.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning SRAM word-address width.
REQ-003 SHALL have parameter LEN_W, default 16, meaning transfer-length counter width.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports cmd_valid/cmd_ready  input/output  1/1  job handshake.
REQ-007 SHALL have ports cmd_input_base, cmd_output_base  input  ADDR_W  job SRAM bases.
REQ-008 SHALL have ports cmd_load_len, cmd_store_len  input  LEN_W  words to write/read.
REQ-009 SHALL have ports in_valid/in_ready/in_data  in/out/in  1/1/DATA_W  load stream.
REQ-010 SHALL have ports out_valid/out_ready/out_data/out_last  out/in/out/out  1/1/DATA_W/1  result stream.
REQ-011 SHALL have ports soc_write_en, soc_addr, soc_data_in  output  1/ADDR_W/DATA_W  SRAM master side (1 = write).
REQ-012 SHALL have port soc_data_out  input  DATA_W  SRAM read data, valid exactly 1 cycle after a read address.
REQ-013 SHALL have ports start, input_base, output_base  output  1/ADDR_W/ADDR_W  accelerator control.
REQ-014 SHALL have ports done input 1 accelerator level done; busy output 1 job in progress.

Function
REQ-015 SHALL implement FSM IDLE -> LOAD -> KICK -> WAIT -> STORE -> IDLE.
REQ-016 IDLE: cmd_ready=1; on cmd_valid&cmd_ready latch all cmd_* fields, next LOAD (or KICK if load_len=0).
REQ-017 LOAD: in_ready=1; each in_valid&in_ready SHALL drive soc_write_en=1, soc_addr=input_base+k, soc_data_in=in_data same cycle, k increments.
REQ-018 LOAD SHALL exit to KICK the cycle after the load_len-th accepted word.
REQ-019 KICK: start=1 for exactly one cycle while done is ignored; next WAIT.
REQ-020 WAIT: start SHALL stay 1 until done=1 sampled, then start=0 next cycle; next STORE (IDLE if store_len=0).
REQ-021 STORE: issue read (soc_write_en=0, soc_addr=output_base+j) only if the 2-entry read buffer has space counting in-flight reads.
REQ-022 Returned soc_data_out SHALL enter the buffer one cycle after issue; buffer head drives out_valid/out_data.
REQ-023 out_last SHALL be 1 with the store_len-th output word; out_valid&out_ready on it returns FSM to IDLE.
REQ-024 Under continuous out_ready=1, STORE SHALL sustain one word per cycle; first out_valid 2 cycles after STORE entry.
REQ-025 Addresses SHALL be base+count modulo 2^ADDR_W (wrap silently).
REQ-026 soc_write_en SHALL be 0 in every state except an accepted LOAD beat.
REQ-027 input_base/output_base outputs SHALL hold latched values from job accept to next accept.
REQ-028 busy SHALL be 1 in every state except IDLE; cmd_ready = !busy.
REQ-029 done=1 outside WAIT SHALL have no effect.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE, counters 0, buffer empty, start=0, soc_write_en=0, out_valid=0, out_last=0, in_ready=0, busy=0, bases 0, soc_addr 0, soc_data_in 0.
REQ-031 Reset mid-job SHALL abandon the job; no further SRAM writes or outputs until a new cmd is accepted.

Structure
REQ-032 FSM state enum and DATA_W/ADDR_W defaults SHALL live in shared package mhsa_pkg.
REQ-033 Read buffer SHALL be a sub-module mhsa_rd_skid (2-entry valid/ready FIFO with count output).

Verification
REQ-034 Job base_in=0, load_len=4, data 0x11..0x44 -> writes at addr 0..3 on consecutive cycles, then one-cycle start.
REQ-035 done raised 10 cycles after KICK, store base 2048 len 512, out_ready=1 -> 512 words in order matching SRAM[2048..2559], out_last on 512th.
REQ-036 out_ready toggled 1/0 each cycle during STORE -> no word lost or duplicated, never more than 2 reads outstanding.
REQ-037 load_len=0 and store_len=0 -> IDLE->KICK->WAIT->IDLE, zero SRAM writes, zero outputs.
REQ-038 input_base=0xFFFFFFFE, load_len=4 -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
REQ-039 rst_n pulsed low in WAIT with start=1 -> start=0 immediately, cmd_ready=1 after release, next job runs normally.
